ctrl_encoder: RTL and testbench

- Inverse of the 3-to-8 control decoder: accepts one-hot control vectors and returns the 3-bit opcode.
- Flags non-one-hot inputs and keeps a saturating error count.
- Valid/ready handshake on both sides, plus a 2-entry skid buffer so back-pressure never drops a word.
- Sits between the control-signal bus and any opcode consumer (trace/replay, checker).

---
 rtl/ctrl_pkg.sv | 21 ++
 rtl/ctrl_onehot_enc.sv | 47 ++++
 rtl/ctrl_encoder.sv | 126 ++++++++++++
 tb/tb_ctrl_encoder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the control-vector encoder: opcode, error kind and skid-buffer state.
package ctrl_pkg;

  localparam int N_CTRL = 8;
  localparam int OPW    = $clog2(N_CTRL);

  typedef logic [OPW-1:0] opcode_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ZERO  = 2'b01,
    ERR_MULTI = 2'b10
  } err_kind_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

endpackage

// File: rtl/ctrl_onehot_enc.sv
// Combinational control-vector to opcode/err_kind encoder, zero latency, no flow control.
// CTRL_ENC_PRIORITY_EN: multi-hot resolves to the highest set bit and reports no error.
module ctrl_onehot_enc
  import ctrl_pkg::*;
#(
  parameter int N_CTRL = 8,
  parameter int OPW    = $clog2(N_CTRL)
) (
  input  logic [N_CTRL-1:0] in_ctrl,
  output logic [OPW-1:0]    opcode,
  output err_kind_t         err_kind
);

  logic is_zero;
  logic is_multi;

  assign is_zero  = ~|in_ctrl;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign is_multi = |(in_ctrl & (in_ctrl - N_CTRL'(1)));

  always_comb begin
    opcode = '0;
`ifdef CTRL_ENC_PRIORITY_EN
    for (int i = 0; i < N_CTRL; i++) begin
      if (in_ctrl[i]) opcode = OPW'(i);
    end
`else
    for (int i = N_CTRL - 1; i >= 0; i--) begin
      if (in_ctrl[i]) opcode = OPW'(i);
    end
`endif
  end

  always_comb begin
    err_kind = ERR_NONE;
    if (is_zero) begin
      err_kind = ERR_ZERO;
    end else if (is_multi) begin
`ifdef CTRL_ENC_PRIORITY_EN
      err_kind = ERR_NONE;
`else
      err_kind = ERR_MULTI;
`endif
    end
  end

endmodule

// File: rtl/ctrl_encoder.sv
// One-hot control vector to opcode encoder with 2-entry skid buffer and saturating error count.
// Latency 1 cycle; in_ready drops only when both registers are full. Option: CTRL_ENC_PRIORITY_EN.
module ctrl_encoder
  import ctrl_pkg::*;
#(
  parameter int N_CTRL = 8,
  parameter int OPW    = 3,
  parameter int CNTW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_CTRL-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPW-1:0]    out_opcode,
  output logic [1:0]        out_err_kind,
  output logic [CNTW-1:0]   err_cnt,
  input  logic              err_cnt_clr
);

  typedef struct packed {
    err_kind_t      kind;
    logic [OPW-1:0] opcode;
  } word_t;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [OPW-1:0] enc_opcode;
  err_kind_t      enc_kind;
  word_t          enc_word;

  skid_state_t     state_q, state_d;
  word_t           out_q, out_d;
  word_t           skid_q, skid_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic [CNTW-1:0] err_cnt_q, err_cnt_d;

  logic accept;
  logic xfer;
  logic count_err;

  ctrl_onehot_enc #(
    .N_CTRL (N_CTRL),
    .OPW    (OPW)
  ) u_enc (
    .in_ctrl  (in_ctrl),
    .opcode   (enc_opcode),
    .err_kind (enc_kind)
  );

  assign enc_word  = '{kind: enc_kind, opcode: enc_opcode};
  assign accept    = in_valid & in_ready_q;
  assign xfer      = out_valid_q & out_ready;
  assign count_err = accept & (enc_kind != ERR_NONE);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = enc_word;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && !xfer) begin
          skid_d  = enc_word;
          state_d = FULL;
        end else if (accept && xfer) begin
          out_d = enc_word;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (xfer) begin
          out_d   = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr) begin
      err_cnt_d = count_err ? CNTW'(1) : '0;
    end else if (count_err && err_cnt_q != CNT_MAX) begin
      err_cnt_d = err_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_q       <= '{kind: ERR_NONE, opcode: '0};
      skid_q      <= '{kind: ERR_NONE, opcode: '0};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_opcode   = out_q.opcode;
  assign out_err_kind = out_q.kind;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ctrl_encoder.sv
// Directed bench for ctrl_encoder: one-hot sweep, error kinds, back-pressure, saturation, async reset.
module tb_ctrl_encoder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_ctrl;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_opcode;
  logic [1:0] out_err_kind;
  logic [7:0] err_cnt;
  logic       err_cnt_clr;

  int vectors;
  int miscompares;

`ifdef CTRL_ENC_PRIORITY_EN
  localparam int MULTI_OP   = 5;
  localparam int MULTI_KIND = 0;
  localparam int ERRS_AFTER = 1;
`else
  localparam int MULTI_OP   = 3;
  localparam int MULTI_KIND = 2;
  localparam int ERRS_AFTER = 2;
`endif

  ctrl_encoder #(
    .N_CTRL (8),
    .OPW    (3),
    .CNTW   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_err_kind (out_err_kind),
    .err_cnt      (err_cnt),
    .err_cnt_clr  (err_cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int base;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_ctrl     = 8'h00;
    out_ready   = 1'b1;
    err_cnt_clr = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_opcode", 32'(out_opcode), 0);
    chk("rst_kind", 32'(out_err_kind), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // One-hot sweep, back-to-back with out_ready high
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_ctrl  = 8'(1 << k);
      tick();
      chk($sformatf("onehot%0d_valid", k), 32'(out_valid), 1);
      chk($sformatf("onehot%0d_opcode", k), 32'(out_opcode), 32'(k));
      chk($sformatf("onehot%0d_kind", k), 32'(out_err_kind), 0);
      chk($sformatf("onehot%0d_ready", k), 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    tick();
    chk("sweep_drain_valid", 32'(out_valid), 0);
    chk("sweep_err_cnt", 32'(err_cnt), 0);

    // Error kinds
    in_valid = 1'b1;
    in_ctrl  = 8'h00;
    tick();
    chk("zero_opcode", 32'(out_opcode), 0);
    chk("zero_kind", 32'(out_err_kind), 1);
    chk("zero_err_cnt", 32'(err_cnt), 1);
    in_ctrl = 8'h28;
    tick();
    chk("multi_opcode", 32'(out_opcode), 32'(MULTI_OP));
    chk("multi_kind", 32'(out_err_kind), 32'(MULTI_KIND));
    in_valid = 1'b0;
    tick();
    chk("errs_err_cnt", 32'(err_cnt), 32'(ERRS_AFTER));
    chk("errs_drain_valid", 32'(out_valid), 0);

    // Back-pressure through the skid register
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h04;
    tick();
    chk("bp1_valid", 32'(out_valid), 1);
    chk("bp1_opcode", 32'(out_opcode), 2);
    chk("bp1_ready", 32'(in_ready), 1);
    in_ctrl = 8'h10;
    tick();
    chk("bp2_opcode", 32'(out_opcode), 2);
    chk("bp2_ready", 32'(in_ready), 0);
    in_ctrl = 8'h40;
    tick();
    chk("bp3_opcode_held", 32'(out_opcode), 2);
    chk("bp3_ready", 32'(in_ready), 0);
    chk("bp3_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    chk("drain1_opcode", 32'(out_opcode), 4);
    chk("drain1_ready", 32'(in_ready), 1);
    tick();
    chk("drain2_opcode", 32'(out_opcode), 6);
    chk("drain2_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    tick();
    chk("drain3_valid", 32'(out_valid), 0);
    chk("bp_err_cnt", 32'(err_cnt), 32'(ERRS_AFTER));

    // Counter saturation
    base     = ERRS_AFTER;
    in_valid = 1'b1;
    in_ctrl  = 8'h00;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 100) chk("sat_mid_err_cnt", 32'(err_cnt), 32'(base + 101));
    end
    chk("sat_err_cnt", 32'(err_cnt), 255);
    err_cnt_clr = 1'b1;
    tick();
    chk("clr_with_err", 32'(err_cnt), 1);
    in_valid = 1'b0;
    tick();
    chk("clr_alone", 32'(err_cnt), 0);
    err_cnt_clr = 1'b0;
    tick();

    // Fill both registers, then reset asynchronously
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h00;
    tick();
    in_ctrl = 8'h01;
    tick();
    in_valid = 1'b0;
    chk("full_ready", 32'(in_ready), 0);
    chk("full_err_cnt", 32'(err_cnt), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ready", 32'(in_ready), 1);
    chk("arst_err_cnt", 32'(err_cnt), 0);
    chk("arst_opcode", 32'(out_opcode), 0);
    chk("arst_kind", 32'(out_err_kind), 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_rst_idle_valid", 32'(out_valid), 0);
    in_valid = 1'b1;
    in_ctrl  = 8'h80;
    tick();
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_opcode", 32'(out_opcode), 7);
    chk("post_rst_kind", 32'(out_err_kind), 0);
    in_valid = 1'b0;
    tick();
    chk("post_rst_drain", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
